// File: rtl/frame_dump_seq.sv
// frame_dump_seq: debounced-trigger raster dump of a frame buffer into a UART byte stream.
// Define FRAME_DUMP_HEADER_EN to prefix each frame with a sync header and escape sync-valued pixels.
module frame_dump_seq #(
    parameter int         WIDTH         = 40,
    parameter int         HEIGHT        = 30,
    parameter int         X_BITS        = 6,
    parameter int         Y_BITS        = 5,
    parameter int         HOLDOFF_BITS  = 13,
    parameter int         DEBOUNCE_BITS = 14,
    parameter logic [7:0] SYNC_BYTE     = 8'hFF
) (
    input  logic              clk12,
    input  logic              areset,
    input  logic              trigger,
    input  logic              continuous,
    output logic [X_BITS-1:0] read_x,
    output logic [Y_BITS-1:0] read_y,
    input  logic [7:0]        read_q,
    input  logic              uart_busy,
    output logic              uart_wr,
    output logic [7:0]        uart_dat,
    output logic              busy,
    output logic              frame_done
);
`ifdef FRAME_DUMP_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif
    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, HEADER, PIXEL, DONE} state_t;

    state_t                   state_q, state_d, first_st;
    logic                     trig_q;
    logic [DEBOUNCE_BITS-1:0] deb_q;
    logic [HOLDOFF_BITS-1:0]  hold_q;
    logic [1:0]               hdr_q, hdr_d;
    logic [X_BITS-1:0]        x_q, x_d;
    logic [Y_BITS-1:0]        y_q, y_d;
    logic                     wr_q, wr_d, busy_q, busy_d, done_q, done_d;
    logic [7:0]               dat_q, dat_d, hdr_byte, pix_byte;
    logic                     start, send_ready, last_x, last_y;

    assign first_st   = HDR_EN ? HEADER : PIXEL;
    assign start      = trig_q && (&deb_q) && (state_q == IDLE);
    assign send_ready = (&hold_q) && !uart_busy && !wr_q;
    assign last_x     = x_q == X_LAST;
    assign last_y     = y_q == Y_LAST;
    assign hdr_byte   = hdr_q[1] ? (hdr_q[0] ? 8'(HEIGHT) : 8'(WIDTH)) : SYNC_BYTE;
    assign pix_byte   = (HDR_EN && read_q == SYNC_BYTE) ? SYNC_BYTE - 8'd1 : read_q;

    // Trigger sync plus saturating debounce and UART holdoff counters
    always_ff @(posedge clk12) begin
        if (areset) begin
            trig_q <= 1'b0;
            deb_q  <= '0;
            hold_q <= '0;
        end else begin
            trig_q <= trigger;
            deb_q  <= trig_q ? '0 : (&deb_q ? deb_q : deb_q + DEBOUNCE_BITS'(1));
            hold_q <= uart_busy ? '0 : (&hold_q ? hold_q : hold_q + HOLDOFF_BITS'(1));
        end
    end

    // Sequencer next state: header bytes, raster pixel walk, one-cycle done
    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        x_d     = x_q;
        y_d     = y_q;
        wr_d    = 1'b0;
        dat_d   = dat_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = first_st;
                hdr_d   = '0;
                x_d     = '0;
                y_d     = '0;
                busy_d  = 1'b1;
            end
            HEADER: if (send_ready) begin
                wr_d    = 1'b1;
                dat_d   = hdr_byte;
                hdr_d   = hdr_q + 2'd1;
                state_d = (hdr_q == 2'd3) ? PIXEL : HEADER;
            end
            PIXEL: if (send_ready) begin
                wr_d    = 1'b1;
                dat_d   = pix_byte;
                x_d     = last_x ? '0 : x_q + X_BITS'(1);
                y_d     = !last_x ? y_q : (last_y ? '0 : y_q + Y_BITS'(1));
                state_d = (last_x && last_y) ? DONE : PIXEL;
            end
            DONE: begin
                done_d  = 1'b1;
                hdr_d   = '0;
                busy_d  = continuous;
                state_d = continuous ? first_st : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk12) begin
        if (areset) begin
            state_q <= IDLE;
            hdr_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            wr_q    <= 1'b0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            wr_q    <= wr_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign read_x     = x_q;
    assign read_y     = y_q;
    assign uart_wr    = wr_q;
    assign uart_dat   = dat_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
endmodule
